// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the fetch/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int unsigned c_cnt_width = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_latency_counter.sv
// ============================================================================
// Module      : mem_latency_counter
// Description : Loadable down-counter that flags when it has reached zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_latency_counter
    import mem_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic [c_cnt_width-1:0] i_load_value,
    input  logic                   i_dec,
    output logic                   o_zero
);

    logic [c_cnt_width-1:0] r_count;

    // Load takes priority; the count saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (fetch/data) arbiter onto a fixed-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ack,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    localparam logic [c_cnt_width-1:0] c_load_value = c_cnt_width'(LATENCY - 1);

    state_t      r_state;
    state_t      w_next_state;
    owner_t      r_owner;
    owner_t      r_last_grant;
    owner_t      w_grant_owner;
    logic        w_grant;
    logic        w_capture;
    logic        w_cnt_zero;
    logic        r_wr;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_i_rdata;
    logic [15:0] r_d_rdata;

    mem_latency_counter u_latency_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_grant),
        .i_load_value (c_load_value),
        .i_dec        (r_state == WAIT),
        .o_zero       (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_grant       = 1'b0;
        w_grant_owner = INST;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    w_grant      = 1'b1;
                    w_next_state = WAIT;
                    // On a tie the port that lost the previous grant wins.
                    if (i_req && d_req) begin
                        w_grant_owner = (r_last_grant == INST) ? DATA : INST;
                    end else if (d_req) begin
                        w_grant_owner = DATA;
                    end else begin
                        w_grant_owner = INST;
                    end
                end
            end
            WAIT: begin
                if (w_cnt_zero) begin
                    w_capture    = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= INST;
            r_last_grant <= INST;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_owner      <= w_grant_owner;
                r_last_grant <= w_grant_owner;
                if (w_grant_owner == DATA) begin
                    r_addr  <= d_addr;
                    r_wdata <= d_wdata;
                    r_wr    <= d_wr;
                end else begin
                    r_addr  <= i_addr;
                    r_wdata <= '0;
                    r_wr    <= 1'b0;
                end
            end
            if (w_capture && !r_wr) begin
                if (r_owner == DATA) begin
                    r_d_rdata <= mem_rdata;
                end else begin
                    r_i_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = (r_state == WAIT);
    assign mem_wr    = mem_en && r_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign i_ack     = (r_state == DONE) && (r_owner == INST);
    assign d_ack     = (r_state == DONE) && (r_owner == DATA);
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire
